pc_update_sequencer: RTL and testbench
======================================

# pc_update_sequencer

Sequencer that drives the PC-source select mux and the PC/EPC/Cause write enables of the multicycle CPU. It accepts one PC-update request per instruction from the main control unit: sequential, branch, jump, return-from-exception or exception. For exceptions it runs a multi-cycle sequence: save EPC, read the handler byte from memory, then load the PC. It sits between the main control FSM and the PC, EPC, Cause and memory-address datapath.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous reset, active-low
- req_valid  in  1  one-cycle request pulse from main control
- req_op  in  3  000 SEQ, 001 BEQ, 010 BNE, 011 JUMP, 100 RTE, 101 EXC; 110/111 illegal
- exc_code  in  2  cause for EXC: 0 invalid opcode, 1 overflow, 2 divide-by-zero, 3 reserved
- alu_zero  in  1  ALU zero flag, sampled with req_valid
- mem_ready  in  1  memory read data valid
- mem_rdata  in  8  memory read byte
- pc_source_ctrl  out  2  mux select: 00 jump target, 01 PC+4, 10 ALUOut branch target, 11 EPC
- pc_write  out  1  PC load enable
- vec_sel  out  1  PC input taken from handler_pc instead of mux, valid only with pc_write
- handler_pc  out  32  zero-extended handler address
- epc_write  out  1  EPC load enable
- cause_write  out  1  Cause register load enable
- cause_out  out  32  exception cause value, zero-extended exc_code
- mem_read  out  1  memory read strobe
- mem_addr  out  32  vector address during handler fetch
- busy  out  1  exception sequence in progress
- done  out  1  one-cycle pulse when a request completes
- req_drop  out  1  one-cycle pulse when req_valid arrives while busy

## Operation
- States: IDLE, EXC_SAVE, EXC_FETCH, EXC_LOAD.
- All outputs are registered. Reset values:
  - pc_source_ctrl=01; handler_pc=0; cause_out=0; mem_addr=0.
  - All strobes, busy and done = 0.
- IDLE, req_valid=1:
  - SEQ: pc_source_ctrl=01, pc_write=1.
  - BEQ: pc_source_ctrl=10; pc_write=alu_zero.
  - BNE: pc_source_ctrl=10; pc_write=!alu_zero.
  - JUMP: pc_source_ctrl=00, pc_write=1.
  - RTE: pc_source_ctrl=11, pc_write=1.
  - For these five ops, done pulses in the same cycle as the strobe and the FSM stays in IDLE.
  - EXC: latch exc_code, then go to EXC_SAVE.
  - Illegal op: same as EXC with code 0.
- EXC_SAVE (1 cycle):
  - epc_write=1, cause_write=1.
  - pc_source_ctrl=01, so EPC captures the ALU result path.
  - cause_out={30'b0,code}.
  - Next state EXC_FETCH.
- EXC_FETCH:
  - mem_read=1.
  - mem_addr = 253 for code 0, 254 for code 1, 255 for codes 2 and 3.
  - Hold until mem_ready=1, then capture handler_pc={24'b0,mem_rdata} and go to EXC_LOAD.
- EXC_LOAD (1 cycle):
  - pc_write=1, vec_sel=1, done=1, then return to IDLE.
- busy=1 in EXC_SAVE, EXC_FETCH and EXC_LOAD.
- req_valid while busy: the request is discarded and req_drop pulses; the sequence is unaffected.
- In IDLE with no request, all strobes are 0 and pc_source_ctrl holds its last value.

## Timing
- Non-exception request: strobes are asserted exactly 1 cycle after the req_valid cycle and last 1 cycle.
- Exception, with mem_ready arriving k cycles after the fetch starts (k>=0):
  - epc_write at T+1.
  - mem_read from T+2 through T+2+k.
  - pc_write/vec_sel/done at T+3+k.
- Back-to-back requests on consecutive cycles in IDLE are each honoured, at 1 per cycle.
- A request arriving in the done cycle of an exception is dropped, because busy is still 1.
- reset low in any state: the next edge forces IDLE and reset values, and no strobes fire in that cycle.

## Configuration
- PC_SEQ_MEM_TIMEOUT_EN defined:
  - A 4-bit counter runs in EXC_FETCH.
  - If mem_ready is not seen within 15 cycles, handler_pc=32'h0000_00FF and the FSM goes to EXC_LOAD.
  - A sticky timeout_flag output is set, cleared only by reset.
- Undefined:
  - EXC_FETCH waits indefinitely.
  - No counter and no timeout_flag port.

## Test plan
- Reset low 2 cycles, then req_valid SEQ -> next cycle pc_source_ctrl=01, pc_write=1, done=1; earlier cycles all strobes 0.
- BEQ with alu_zero=0, then BNE with alu_zero=0 on consecutive cycles:
  - First request: pc_source_ctrl=10, pc_write=0.
  - Second request: pc_source_ctrl=10, pc_write=1.
- EXC code 1 with mem_ready after 3 cycles and mem_rdata=8'h40:
  - epc_write and cause_write at T+1, cause_out=1.
  - mem_addr=254 for 4 cycles.
  - At T+6: pc_write=1, vec_sel=1, handler_pc=32'h40.
- Illegal op 111 -> mem_addr=253, cause_out=0; JUMP issued during EXC_FETCH -> req_drop=1, sequence intact.
- Reset asserted during EXC_FETCH -> IDLE next edge, busy=0, mem_read=0, no pc_write; a following RTE gives pc_source_ctrl=11.
- With PC_SEQ_MEM_TIMEOUT_EN and mem_ready held 0 -> after 15 fetch cycles, handler_pc=32'hFF, pc_write=1, vec_sel=1, timeout_flag=1.

Source files
------------

// File: rtl/pc_update_sequencer.sv
// pc_update_sequencer: drives the PC-source mux select and the PC/EPC/Cause
// write enables of the multicycle CPU. Simple PC updates (SEQ/BEQ/BNE/JUMP/RTE)
// complete in one cycle. An exception runs SAVE -> FETCH -> LOAD: save EPC and
// Cause, read the handler byte from the vector table, then load the PC.
// All outputs are registered, so every strobe appears one cycle after the
// decision that produced it.
// Optional feature macro: PC_SEQ_MEM_TIMEOUT_EN. When it is defined, a 4-bit
// fetch watchdog is added, along with a sticky timeout_flag output.
module pc_update_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [1:0]  exc_code,
  input  logic        alu_zero,
  input  logic        mem_ready,
  input  logic [7:0]  mem_rdata,
  output logic [1:0]  pc_source_ctrl,
  output logic        pc_write,
  output logic        vec_sel,
  output logic [31:0] handler_pc,
  output logic        epc_write,
  output logic        cause_write,
  output logic [31:0] cause_out,
  output logic        mem_read,
  output logic [31:0] mem_addr,
  output logic        busy,
  output logic        done,
  output logic        req_drop
`ifdef PC_SEQ_MEM_TIMEOUT_EN
  ,
  output logic        timeout_flag
`endif
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    EXC_SAVE  = 2'd1,
    EXC_FETCH = 2'd2,
    EXC_LOAD  = 2'd3
  } state_t;

  localparam logic [2:0] OP_SEQ  = 3'b000;
  localparam logic [2:0] OP_BEQ  = 3'b001;
  localparam logic [2:0] OP_BNE  = 3'b010;
  localparam logic [2:0] OP_JUMP = 3'b011;
  localparam logic [2:0] OP_RTE  = 3'b100;
  localparam logic [2:0] OP_EXC  = 3'b101;

  // Vector-table slot holding the handler byte for each cause code
  function automatic logic [31:0] vec_addr(input logic [1:0] code);
    case (code)
      2'd0:    vec_addr = 32'd253;
      2'd1:    vec_addr = 32'd254;
      default: vec_addr = 32'd255;
    endcase
  endfunction

  state_t      r_state, w_next_state;
  logic [1:0]  r_code, w_code;
  logic [1:0]  r_pc_src, w_pc_src;
  logic        r_pc_write, w_pc_write;
  logic        r_vec_sel, w_vec_sel;
  logic [31:0] r_handler_pc, w_handler_pc;
  logic        r_epc_write, w_epc_write;
  logic        r_cause_write, w_cause_write;
  logic [31:0] r_cause_out, w_cause_out;
  logic        r_mem_read, w_mem_read;
  logic [31:0] r_mem_addr, w_mem_addr;
  logic        r_busy, w_busy;
  logic        r_done, w_done;
  logic        r_req_drop, w_req_drop;
`ifdef PC_SEQ_MEM_TIMEOUT_EN
  logic [3:0]  r_cnt, w_cnt;
  logic        r_timeout, w_timeout;
`endif

  // Next state and next registered output values; held values default to current
  always_comb begin
    w_next_state  = r_state;
    w_code        = r_code;
    w_pc_src      = r_pc_src;
    w_pc_write    = 1'b0;
    w_vec_sel     = 1'b0;
    w_handler_pc  = r_handler_pc;
    w_epc_write   = 1'b0;
    w_cause_write = 1'b0;
    w_cause_out   = r_cause_out;
    w_mem_read    = 1'b0;
    w_mem_addr    = r_mem_addr;
    w_done        = 1'b0;
    w_req_drop    = 1'b0;
`ifdef PC_SEQ_MEM_TIMEOUT_EN
    w_cnt         = r_cnt;
    w_timeout     = r_timeout;
`endif
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          case (req_op)
            OP_SEQ:  begin w_pc_src = 2'b01; w_pc_write = 1'b1;      w_done = 1'b1; end
            OP_BEQ:  begin w_pc_src = 2'b10; w_pc_write = alu_zero;  w_done = 1'b1; end
            OP_BNE:  begin w_pc_src = 2'b10; w_pc_write = !alu_zero; w_done = 1'b1; end
            OP_JUMP: begin w_pc_src = 2'b00; w_pc_write = 1'b1;      w_done = 1'b1; end
            OP_RTE:  begin w_pc_src = 2'b11; w_pc_write = 1'b1;      w_done = 1'b1; end
            default: begin
              // EXC uses the supplied cause; illegal ops report invalid opcode
              w_code        = (req_op == OP_EXC) ? exc_code : 2'd0;
              w_next_state  = EXC_SAVE;
              w_epc_write   = 1'b1;
              w_cause_write = 1'b1;
              w_pc_src      = 2'b01;
              w_cause_out   = {30'b0, w_code};
            end
          endcase
        end
      end
      EXC_SAVE: begin
        w_req_drop   = req_valid;
        w_next_state = EXC_FETCH;
        w_mem_read   = 1'b1;
        w_mem_addr   = vec_addr(r_code);
`ifdef PC_SEQ_MEM_TIMEOUT_EN
        w_cnt        = 4'd0;
`endif
      end
      EXC_FETCH: begin
        w_req_drop = req_valid;
        if (mem_ready) begin
          w_next_state = EXC_LOAD;
          w_handler_pc = {24'b0, mem_rdata};
          w_pc_write   = 1'b1;
          w_vec_sel    = 1'b1;
          w_done       = 1'b1;
`ifdef PC_SEQ_MEM_TIMEOUT_EN
        end else if (r_cnt == 4'd14) begin
          // Fifteenth fetch cycle without data: fall back to the default handler
          w_next_state = EXC_LOAD;
          w_handler_pc = 32'h0000_00FF;
          w_pc_write   = 1'b1;
          w_vec_sel    = 1'b1;
          w_done       = 1'b1;
          w_timeout    = 1'b1;
        end else begin
          w_mem_read = 1'b1;
          w_cnt      = r_cnt + 4'd1;
`else
        end else begin
          w_mem_read = 1'b1;
`endif
        end
      end
      EXC_LOAD: begin
        w_req_drop   = req_valid;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
    w_busy = (w_next_state != IDLE);
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Registered outputs and latched exception context
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_code        <= 2'd0;
      r_pc_src      <= 2'b01;
      r_pc_write    <= 1'b0;
      r_vec_sel     <= 1'b0;
      r_handler_pc  <= 32'd0;
      r_epc_write   <= 1'b0;
      r_cause_write <= 1'b0;
      r_cause_out   <= 32'd0;
      r_mem_read    <= 1'b0;
      r_mem_addr    <= 32'd0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_req_drop    <= 1'b0;
`ifdef PC_SEQ_MEM_TIMEOUT_EN
      r_cnt         <= 4'd0;
      r_timeout     <= 1'b0;
`endif
    end else begin
      r_code        <= w_code;
      r_pc_src      <= w_pc_src;
      r_pc_write    <= w_pc_write;
      r_vec_sel     <= w_vec_sel;
      r_handler_pc  <= w_handler_pc;
      r_epc_write   <= w_epc_write;
      r_cause_write <= w_cause_write;
      r_cause_out   <= w_cause_out;
      r_mem_read    <= w_mem_read;
      r_mem_addr    <= w_mem_addr;
      r_busy        <= w_busy;
      r_done        <= w_done;
      r_req_drop    <= w_req_drop;
`ifdef PC_SEQ_MEM_TIMEOUT_EN
      r_cnt         <= w_cnt;
      r_timeout     <= w_timeout;
`endif
    end
  end

  assign pc_source_ctrl = r_pc_src;
  assign pc_write       = r_pc_write;
  assign vec_sel        = r_vec_sel;
  assign handler_pc     = r_handler_pc;
  assign epc_write      = r_epc_write;
  assign cause_write    = r_cause_write;
  assign cause_out      = r_cause_out;
  assign mem_read       = r_mem_read;
  assign mem_addr       = r_mem_addr;
  assign busy           = r_busy;
  assign done           = r_done;
  assign req_drop       = r_req_drop;
`ifdef PC_SEQ_MEM_TIMEOUT_EN
  assign timeout_flag   = r_timeout;
`endif

endmodule

// File: tb/tb_pc_update_sequencer.sv
// Scoreboard bench for pc_update_sequencer. Directed stimulus pushes the
// hand-computed output snapshot expected for every cycle in which the DUT
// raises any strobe; a monitor pops and compares on each such cycle.
module tb_pc_update_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic [1:0]  exc_code = 2'd0;
  logic        alu_zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic [7:0]  mem_rdata = 8'd0;
  logic [1:0]  pc_source_ctrl;
  logic        pc_write, vec_sel, epc_write, cause_write, mem_read;
  logic        busy, done, req_drop;
  logic [31:0] handler_pc, cause_out, mem_addr;
`ifdef PC_SEQ_MEM_TIMEOUT_EN
  logic        timeout_flag;
`endif

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  typedef struct packed {
    logic [1:0]  src;
    logic        pcw, vec, epc, cw, mr, dn, drop, bsy;
    logic [31:0] cause, maddr, hpc;
  } snap_t;

  snap_t exp_q[$];

  pc_update_sequencer dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .exc_code(exc_code), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .pc_source_ctrl(pc_source_ctrl), .pc_write(pc_write),
    .vec_sel(vec_sel), .handler_pc(handler_pc), .epc_write(epc_write),
    .cause_write(cause_write), .cause_out(cause_out), .mem_read(mem_read),
    .mem_addr(mem_addr), .busy(busy), .done(done), .req_drop(req_drop)
`ifdef PC_SEQ_MEM_TIMEOUT_EN
    , .timeout_flag(timeout_flag)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] src, input logic pcw, input logic vec,
                      input logic epc, input logic cw, input logic mr,
                      input logic dn, input logic drop, input logic bsy,
                      input logic [31:0] cause, input logic [31:0] maddr,
                      input logic [31:0] hpc);
    snap_t s;
    s = '{src, pcw, vec, epc, cw, mr, dn, drop, bsy, cause, maddr, hpc};
    exp_q.push_back(s);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Pops and compares one expected snapshot on every cycle with a live strobe
  task automatic monitor();
    snap_t a, e;
    forever begin
      @(negedge clk);
      if (mon_en && ((pc_write === 1'b1) || (vec_sel === 1'b1) || (epc_write === 1'b1) ||
                     (cause_write === 1'b1) || (mem_read === 1'b1) || (done === 1'b1) ||
                     (req_drop === 1'b1))) begin
        a = '{pc_source_ctrl, pc_write, vec_sel, epc_write, cause_write, mem_read,
              done, req_drop, busy, cause_out, mem_addr, handler_pc};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe t=%0t actual src=%b pcw=%b vec=%b epc=%b cw=%b mr=%b done=%b drop=%b required no strobe",
                   $time, a.src, a.pcw, a.vec, a.epc, a.cw, a.mr, a.dn, a.drop);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            errors++;
            $display("FAIL cycle_snapshot t=%0t actual src=%b pcw=%b vec=%b epc=%b cw=%b mr=%b done=%b drop=%b busy=%b cause=%h maddr=%h hpc=%h required src=%b pcw=%b vec=%b epc=%b cw=%b mr=%b done=%b drop=%b busy=%b cause=%h maddr=%h hpc=%h",
                     $time, a.src, a.pcw, a.vec, a.epc, a.cw, a.mr, a.dn, a.drop, a.bsy, a.cause, a.maddr, a.hpc,
                     e.src, e.pcw, e.vec, e.epc, e.cw, e.mr, e.dn, e.drop, e.bsy, e.cause, e.maddr, e.hpc);
          end
        end
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    // Reset low for two edges, then check reset values
    step(); step();
    chk("reset_src", {30'b0, pc_source_ctrl}, 32'd1);
    chk("reset_strobes", {24'b0, pc_write, vec_sel, epc_write, cause_write, mem_read, busy, done, req_drop}, 32'd0);
    chk("reset_handler_pc", handler_pc, 32'd0);
    chk("reset_cause_out", cause_out, 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    reset = 1'b1;
    mon_en = 1'b1;
    step(); step();

    // SEQ
    push(2'b01, 1, 0, 0, 0, 0, 1, 0, 0, 32'd0, 32'd0, 32'd0);
    req_valid = 1; req_op = 3'b000; step(); req_valid = 0; step();

    // BEQ z=0 then BNE z=0 back to back, then JUMP, BEQ z=1, BNE z=1 back to back
    push(2'b10, 0, 0, 0, 0, 0, 1, 0, 0, 32'd0, 32'd0, 32'd0);
    push(2'b10, 1, 0, 0, 0, 0, 1, 0, 0, 32'd0, 32'd0, 32'd0);
    push(2'b00, 1, 0, 0, 0, 0, 1, 0, 0, 32'd0, 32'd0, 32'd0);
    push(2'b10, 1, 0, 0, 0, 0, 1, 0, 0, 32'd0, 32'd0, 32'd0);
    push(2'b10, 0, 0, 0, 0, 0, 1, 0, 0, 32'd0, 32'd0, 32'd0);
    req_valid = 1; alu_zero = 0;
    req_op = 3'b001; step();
    req_op = 3'b010; step();
    req_op = 3'b011; step();
    alu_zero = 1;
    req_op = 3'b001; step();
    req_op = 3'b010; step();
    req_valid = 0; alu_zero = 0; step(); step();

    // EXC code 1, mem_ready three cycles after fetch starts, handler byte 40
    push(2'b01, 0, 0, 1, 1, 0, 0, 0, 1, 32'd1, 32'd0, 32'd0);
    for (int i = 0; i < 4; i++)
      push(2'b01, 0, 0, 0, 0, 1, 0, 0, 1, 32'd1, 32'd254, 32'd0);
    push(2'b01, 1, 1, 0, 0, 0, 1, 0, 1, 32'd1, 32'd254, 32'h40);
    req_valid = 1; req_op = 3'b101; exc_code = 2'd1; step();
    req_valid = 0;
    step(); step(); step(); step();
    mem_ready = 1; mem_rdata = 8'h40; step();
    mem_ready = 0; step(); step();
    chk("exc1_idle_busy", {31'b0, busy}, 32'd0);

    // Illegal op 111 (code forced 0), JUMP dropped during fetch, RTE dropped in done cycle
    push(2'b01, 0, 0, 1, 1, 0, 0, 0, 1, 32'd0, 32'd254, 32'h40);
    push(2'b01, 0, 0, 0, 0, 1, 0, 0, 1, 32'd0, 32'd253, 32'h40);
    push(2'b01, 0, 0, 0, 0, 1, 0, 1, 1, 32'd0, 32'd253, 32'h40);
    push(2'b01, 0, 0, 0, 0, 1, 0, 0, 1, 32'd0, 32'd253, 32'h40);
    push(2'b01, 1, 1, 0, 0, 0, 1, 0, 1, 32'd0, 32'd253, 32'h8C);
    push(2'b01, 0, 0, 0, 0, 0, 0, 1, 0, 32'd0, 32'd253, 32'h8C);
    req_valid = 1; req_op = 3'b111; exc_code = 2'd2; step();
    req_valid = 0; step();
    req_valid = 1; req_op = 3'b011; step();
    req_valid = 0; step();
    mem_ready = 1; mem_rdata = 8'h8C; step();
    mem_ready = 0; req_valid = 1; req_op = 3'b100; step();
    req_valid = 0; step(); step();

    // EXC code 3, reset asserted during fetch, then RTE
    push(2'b01, 0, 0, 1, 1, 0, 0, 0, 1, 32'd3, 32'd253, 32'h8C);
    push(2'b01, 0, 0, 0, 0, 1, 0, 0, 1, 32'd3, 32'd255, 32'h8C);
    push(2'b01, 0, 0, 0, 0, 1, 0, 0, 1, 32'd3, 32'd255, 32'h8C);
    req_valid = 1; req_op = 3'b101; exc_code = 2'd3; step();
    req_valid = 0; step(); step();
    reset = 1'b0; step();
    chk("rst_fetch_busy", {31'b0, busy}, 32'd0);
    chk("rst_fetch_mem_read", {31'b0, mem_read}, 32'd0);
    chk("rst_fetch_pc_write", {31'b0, pc_write}, 32'd0);
    chk("rst_fetch_mem_addr", mem_addr, 32'd0);
    chk("rst_fetch_handler", handler_pc, 32'd0);
    reset = 1'b1; step();
    push(2'b11, 1, 0, 0, 0, 0, 1, 0, 0, 32'd0, 32'd0, 32'd0);
    req_valid = 1; req_op = 3'b100; step();
    req_valid = 0; step(); step();
    chk("rte_src_held", {30'b0, pc_source_ctrl}, 32'd3);

`ifdef PC_SEQ_MEM_TIMEOUT_EN
    // EXC code 0 with mem_ready never arriving: watchdog after 15 fetch cycles
    push(2'b01, 0, 0, 1, 1, 0, 0, 0, 1, 32'd0, 32'd0, 32'd0);
    for (int i = 0; i < 15; i++)
      push(2'b01, 0, 0, 0, 0, 1, 0, 0, 1, 32'd0, 32'd253, 32'd0);
    push(2'b01, 1, 1, 0, 0, 0, 1, 0, 1, 32'd0, 32'd253, 32'hFF);
    chk("timeout_flag_clear", {31'b0, timeout_flag}, 32'd0);
    req_valid = 1; req_op = 3'b101; exc_code = 2'd0; step();
    req_valid = 0;
    for (int i = 0; i < 19; i++) step();
    chk("timeout_flag_set", {31'b0, timeout_flag}, 32'd1);
`endif

    step(); step();
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit in case the stimulus ever stalls
  initial begin
    #100000;
    $display("FAIL time_limit actual=expired required=finish");
    $fatal(1);
  end

endmodule
